result_bcd_display: RTL and testbench

//  Downstream consumer of the calculator's 10-bit sqrt Result/Done pair. Captures Value when Load rises.

---
 rtl/result_bcd_display_pkg.sv | 24 ++
 rtl/result_bcd_display_bcd_seg7_decoder.sv | 32 +++
 rtl/result_bcd_display.sv | 169 ++++++++++++++++
 tb/tb_result_bcd_display.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/result_bcd_display_pkg.sv
// Shared definitions for the result BCD display block.
//   state_t    : conversion FSM states (IDLE -> CONV -> COMMIT -> IDLE)
//   SEG_*      : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
package result_bcd_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/result_bcd_display_bcd_seg7_decoder.sv
// Combinational BCD nibble to 7-segment decoder (active-low segments).
//   nibble : BCD digit 0..9; codes 10..15 decode to blank
//   blank  : force all segments off
//   seg    : {g,f,e,d,c,b,a}, active-low
module bcd_seg7_decoder
    import result_bcd_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_bcd_display.sv
// Captures a binary result on the rising edge of Load, converts it to BCD with a
// sequential double-dabble (one bit per clock) and shows the last completed result
// on a time-multiplexed 4-digit 7-segment display.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low
//   Load   : start request, rising edge significant
//   Value  : binary value, sampled on the Load rising-edge cycle
//   Busy   : conversion in progress
//   Ready  : one-cycle pulse when bcd updates
//   bcd    : last completed BCD result, digit 0 in [3:0]
//   seg    : active-low segments {g,f,e,d,c,b,a}
//   an     : active-low digit enables, exactly one low
//
// Handshake: Load is a level or pulse; only its 0->1 transition starts work. Any
// new rising edge, even mid-conversion, restarts from the current Value. Ready is
// a single-cycle strobe coinciding with the bcd update; there is no back-pressure.
module result_bcd_display
    import result_bcd_display_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Load,
    input  logic [WIDTH-1:0]    Value,
    output logic                Busy,
    output logic                Ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // One double-dabble step: add 3 to each BCD nibble >= 5 (no inter-nibble
    // carry), then shift the whole register left by one.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] s);
        logic [SR_W-1:0] t;
        t = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (t[WIDTH+4*i +: 4] >= 4'd5)
                t[WIDTH+4*i +: 4] = t[WIDTH+4*i +: 4] + 4'd3;
        end
        return t << 1;
    endfunction

    // ---------------------------------------------------------------
    // Conversion FSM and datapath
    // ---------------------------------------------------------------
    state_t            state, state_next;
    logic [SR_W-1:0]   sr_q, sr_next;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
    logic [BCD_W-1:0]  bcd_q, bcd_next;
    logic              busy_q, busy_next;
    logic              ready_q, ready_next;
    logic              load_d;
    logic              start;

    assign start = Load & ~load_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            sr_q    <= '0;
            bit_cnt <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            load_d  <= 1'b0;
        end else begin
            state   <= state_next;
            sr_q    <= sr_next;
            bit_cnt <= bit_cnt_next;
            bcd_q   <= bcd_next;
            busy_q  <= busy_next;
            ready_q <= ready_next;
            load_d  <= Load;
        end
    end

    always_comb begin
        state_next   = state;
        sr_next      = sr_q;
        bit_cnt_next = bit_cnt;
        bcd_next     = bcd_q;
        busy_next    = busy_q;
        ready_next   = 1'b0;
        if (start) begin
            // A start in any state (re)loads; an in-flight result is discarded.
            sr_next      = {{BCD_W{1'b0}}, Value};
            bit_cnt_next = CNT_W'(WIDTH);
            state_next   = ST_CONV;
            busy_next    = 1'b1;
        end else begin
            case (state)
                ST_CONV: begin
                    sr_next      = dabble_step(sr_q);
                    bit_cnt_next = bit_cnt - 1'b1;
                    if (bit_cnt == CNT_W'(1))
                        state_next = ST_COMMIT;
                end
                ST_COMMIT: begin
                    bcd_next   = sr_q[SR_W-1 -: BCD_W];
                    ready_next = 1'b1;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign Busy  = busy_q;
    assign Ready = ready_q;
    assign bcd   = bcd_q;

    // ---------------------------------------------------------------
    // Display refresh: free-running, independent of the FSM
    // ---------------------------------------------------------------
    logic [REF_W-1:0] refresh_cnt;
    logic [IDX_W-1:0] digit_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            if (digit_idx == IDX_W'(DIGITS - 1))
                digit_idx <= '0;
            else
                digit_idx <= digit_idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Digit k is a leading zero when it and every higher digit are zero.
    // Digit 0 is never blanked so a zero result still shows "0".
    logic [DIGITS-1:0] blank_lz;
    logic              zero_above;

    always_comb begin
        blank_lz   = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zero_above  = zero_above & (bcd_q[4*k +: 4] == 4'd0);
            blank_lz[k] = (BLANK_LZ != 0) && zero_above;
        end
    end

    assign an = ~(DIGITS'(1) << digit_idx);

    bcd_seg7_decoder u_dec (
        .nibble (bcd_q[4*digit_idx +: 4]),
        .blank  (blank_lz[digit_idx]),
        .seg    (seg)
    );

endmodule

// File: tb/tb_result_bcd_display.sv
module tb_result_bcd_display;

    logic        clk;
    logic        reset;
    logic        Load;
    logic [9:0]  Value;
    logic        Busy;
    logic        Ready;
    logic [15:0] bcd;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side display model and expected displayed result
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] exp_bcd = 16'h0000;

    result_bcd_display #(
        .WIDTH       (10),
        .DIGITS      (4),
        .REFRESH_DIV (4),
        .BLANK_LZ    (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Load  (Load),
        .Value (Value),
        .Busy  (Busy),
        .Ready (Ready),
        .bcd   (bcd),
        .seg   (seg),
        .an    (an)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] b, input int idx);
        logic [15:0] upper;
        upper = b >> (4 * idx);
        if (idx > 0 && upper == 16'h0000)
            return 7'b1111111;
        return seg_of(upper[3:0]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (reset) begin
            if (m_cnt == 3) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_disp(input string tag);
        logic [3:0] exp_an;
        exp_an = ~(4'b0001 << m_idx);
        check({tag, "_an"}, 32'(an), 32'(exp_an));
        check({tag, "_seg"}, 32'(seg), 32'(exp_seg(exp_bcd, m_idx)));
    endtask

    // Pulse Load with value v and follow the conversion to completion.
    task automatic convert(input int v, input bit detailed, input string tag);
        int rdy;
        Value = 10'(v);
        Load  = 1'b1;
        step();                       // edge T0
        Load = 1'b0;
        if (detailed) check({tag, "_busy_t0"}, 32'(Busy), 32'd1);
        rdy = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (Ready) rdy++;
            if (detailed) check({tag, "_busy_conv"}, 32'(Busy), 32'd1);
        end
        step();                       // edge T0+11
        check({tag, "_ready_early"}, 32'(rdy), 32'd0);
        check({tag, "_ready"}, 32'(Ready), 32'd1);
        check({tag, "_bcd"}, 32'(bcd), 32'(to_bcd(v)));
        if (detailed) check({tag, "_busy_done"}, 32'(Busy), 32'd0);
        exp_bcd = to_bcd(v);
        step();
        check({tag, "_ready_1cyc"}, 32'(Ready), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rdy;
        reset = 1'b0;
        Load  = 1'b0;
        Value = '0;

        // Reset held
        repeat (3) step();
        check("rst_bcd", 32'(bcd), 32'h0000);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_ready", 32'(Ready), 32'd0);
        check("rst_an", 32'(an), 32'b1110);
        check("rst_seg", 32'(seg), 32'b1000000);

        // Release, idle display scan with leading-zero blanking
        reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            check_disp("idle_disp");
        end
        check("idle_busy", 32'(Busy), 32'd0);

        // 1023: full-width value, every digit lit
        convert(1023, 1'b1, "v1023");
        for (int i = 0; i < 16; i++) begin
            step();
            check_disp("v1023_disp");
        end

        // 255 with Load held high for 30 cycles: one conversion only
        Value = 10'd255;
        Load  = 1'b1;
        rdy   = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (Ready) rdy++;
        end
        Load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (Ready) rdy++;
        end
        check("hold_ready_count", 32'(rdy), 32'd1);
        check("hold_bcd", 32'(bcd), 32'h0255);
        check("hold_busy", 32'(Busy), 32'd0);
        exp_bcd = 16'h0255;
        for (int i = 0; i < 16; i++) begin
            step();
            check_disp("hold_disp");
        end

        // Restart: 15 at T0, 7 at T0+5
        Value = 10'd15;
        Load  = 1'b1;
        step();                               // T0
        Load = 1'b0;
        for (int i = 1; i <= 4; i++) step();  // T0+4
        Value = 10'd7;
        Load  = 1'b1;
        step();                               // T0+5
        Load = 1'b0;
        check("restart_busy", 32'(Busy), 32'd1);
        rdy = 0;
        for (int i = 6; i <= 11; i++) begin
            step();
            if (Ready) rdy++;
        end
        check("restart_no_ready_t11", 32'(rdy), 32'd0);
        check("restart_busy_t11", 32'(Busy), 32'd1);
        check("restart_bcd_kept", 32'(bcd), 32'h0255);
        for (int i = 12; i <= 15; i++) begin
            step();
            if (Ready) rdy++;
        end
        step();                               // T0+16
        check("restart_no_ready_mid", 32'(rdy), 32'd0);
        check("restart_ready_t16", 32'(Ready), 32'd1);
        check("restart_bcd", 32'(bcd), 32'h0007);
        exp_bcd = 16'h0007;
        step();
        check_disp("restart_disp");

        // Async reset mid-conversion
        convert(512, 1'b0, "v512");
        Value = 10'd99;
        Load  = 1'b1;
        step();                               // T0'
        Load = 1'b0;
        for (int i = 1; i <= 4; i++) step();  // T0'+4
        reset = 1'b0;
        m_cnt = 0;
        m_idx = 0;
        exp_bcd = 16'h0000;
        #1;
        check("midrst_bcd", 32'(bcd), 32'h0000);
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_ready", 32'(Ready), 32'd0);
        check_disp("midrst_disp");
        step();
        step();
        check("midrst_hold_bcd", 32'(bcd), 32'h0000);
        reset = 1'b1;
        step();
        check_disp("postrst_disp");
        convert(123, 1'b1, "v123");

        // Sweep every value against the decimal reference
        for (int v = 0; v < 1024; v++) convert(v, 1'b0, "sweep");
        for (int i = 0; i < 4; i++) begin
            step();
            check_disp("sweep_disp");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
